// File: rtl/alu_fuzz_engine_if.sv
// Stimulus/response bundle between the fuzz engine and the ALU under test.
// The engine owns the vector and status signals; the ALU side returns result_i.
interface alu_fuzz_engine_if;
  logic        start_i;
  logic [10:0] seed_i;
  logic [3:0]  a_o;
  logic [3:0]  b_o;
  logic [2:0]  opcode_o;
  logic        vec_valid_o;
  logic [3:0]  result_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] signature_o;
  logic [7:0]  count_o;

  modport master (
    output start_i,
    output seed_i,
    output result_i,
    input  a_o,
    input  b_o,
    input  opcode_o,
    input  vec_valid_o,
    input  busy_o,
    input  done_o,
    input  signature_o,
    input  count_o
  );

  modport slave (
    input  start_i,
    input  seed_i,
    input  result_i,
    output a_o,
    output b_o,
    output opcode_o,
    output vec_valid_o,
    output busy_o,
    output done_o,
    output signature_o,
    output count_o
  );
endinterface

// File: rtl/alu_fuzz_engine.sv
// ALU fuzz engine: an 11-bit LFSR (x^11+x^9+1) generates operand/opcode
// vectors, each held for SETTLE cycles, after which the returned ALU result
// is folded into a 16-bit MISR signature. A run covers NUM_VECTORS vectors
// and ends with a one-cycle done_o pulse.
module alu_fuzz_engine #(
  parameter int unsigned NUM_VECTORS = 10,
  parameter int unsigned SETTLE      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_fuzz_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] N_LAST = 8'(NUM_VECTORS);
  localparam logic [3:0] S_LAST = 4'(SETTLE - 1);

  state_t      state;
  logic [10:0] lfsr;
  logic [15:0] sig;
  logic [7:0]  cnt;
  logic [3:0]  settle_cnt;
  logic        vec_valid;
  logic        busy;
  logic        done;

  logic [10:0] lfsr_nxt;
  logic [10:0] seed_load;
  logic [15:0] sig_nxt;
  logic [7:0]  cnt_nxt;

  // Next-value arithmetic for the LFSR, MISR and vector counter.
  always_comb begin
    lfsr_nxt  = {lfsr[9:0], lfsr[10] ^ lfsr[8]};
    seed_load = (bus.seed_i == '0) ? 11'h001 : bus.seed_i;
    sig_nxt   = {sig[14:0], sig[15] ^ sig[14] ^ sig[12] ^ sig[3]}
              ^ {12'b0, bus.result_i};
    cnt_nxt   = cnt + 8'd1;
  end

  // Run sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= '0;
      sig        <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
      vec_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
          if (bus.start_i) begin
            lfsr       <= seed_load;
            sig        <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
            vec_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == S_LAST) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          sig        <= sig_nxt;
          cnt        <= cnt_nxt;
          lfsr       <= lfsr_nxt;
          settle_cnt <= '0;
          if (cnt_nxt == N_LAST) begin
            vec_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_o         = lfsr[10:7];
  assign bus.b_o         = lfsr[6:3];
  assign bus.opcode_o    = lfsr[2:0];
  assign bus.vec_valid_o = vec_valid;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.signature_o = sig;
  assign bus.count_o     = cnt;

endmodule

// File: tb/tb_alu_fuzz_engine.sv
// Self-checking bench for alu_fuzz_engine: three instances (default,
// NUM_VECTORS=2, SETTLE=3), a golden ALU closing the loop, and a
// vector-list/MISR reference model computed from the LFSR/MISR rules.
module tb_alu_fuzz_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam int N_OF [3] = '{10, 2, 10};
  localparam int S_OF [3] = '{1, 1, 3};

  logic        start_v [3];
  logic [10:0] seed_v;
  logic [3:0]  tie_val;
  int          sel;

  alu_fuzz_engine_if if0 ();
  alu_fuzz_engine_if if1 ();
  alu_fuzz_engine_if if2 ();

  alu_fuzz_engine #(.NUM_VECTORS(10), .SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  alu_fuzz_engine #(.NUM_VECTORS(2),  .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  alu_fuzz_engine #(.NUM_VECTORS(10), .SETTLE(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return {a[0], a[3:1]};
    endcase
  endfunction

  assign if0.start_i  = start_v[0];
  assign if1.start_i  = start_v[1];
  assign if2.start_i  = start_v[2];
  assign if0.seed_i   = seed_v;
  assign if1.seed_i   = seed_v;
  assign if2.seed_i   = seed_v;
  assign if0.result_i = alu(if0.a_o, if0.b_o, if0.opcode_o);
  assign if1.result_i = tie_val;
  assign if2.result_i = alu(if2.a_o, if2.b_o, if2.opcode_o);

  // Packed view {a,b,op,vv,busy,done,sig,cnt} of each instance.
  logic [37:0] pk [3];
  assign pk[0] = {if0.a_o, if0.b_o, if0.opcode_o, if0.vec_valid_o, if0.busy_o, if0.done_o, if0.signature_o, if0.count_o};
  assign pk[1] = {if1.a_o, if1.b_o, if1.opcode_o, if1.vec_valid_o, if1.busy_o, if1.done_o, if1.signature_o, if1.count_o};
  assign pk[2] = {if2.a_o, if2.b_o, if2.opcode_o, if2.vec_valid_o, if2.busy_o, if2.done_o, if2.signature_o, if2.count_o};

  logic [37:0] o_pk;
  logic [10:0] o_vec;
  logic        o_vv, o_busy, o_done;
  logic [15:0] o_sig;
  logic [7:0]  o_cnt;
  always_comb begin
    o_pk   = pk[sel];
    o_vec  = o_pk[37:27];
    o_vv   = o_pk[26];
    o_busy = o_pk[25];
    o_done = o_pk[24];
    o_sig  = o_pk[23:8];
    o_cnt  = o_pk[7:0];
  end

  // Reference model results
  logic [10:0] exp_vecs [$];
  logic [15:0] exp_sig;
  logic [10:0] exp_last;

  task automatic model_run(input logic [10:0] seed, input int n, input bit use_alu, input logic [3:0] tie);
    logic [10:0] l;
    logic [15:0] s;
    logic [3:0]  r;
    exp_vecs.delete();
    l = (seed == 0) ? 11'h001 : seed;
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      exp_vecs.push_back(l);
      r = use_alu ? alu(l[10:7], l[6:3], l[2:0]) : tie;
      s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {12'h000, r};
      l = {l[9:0], l[10] ^ l[8]};
    end
    exp_sig  = s;
    exp_last = l;
  endtask

  // Capture results of one run
  logic [10:0] obs_vecs [$];
  int          c_first_vv, c_last_vv, c_vv_cycles, c_first_done, c_done_cycles;
  logic [15:0] c_sig;
  logic [7:0]  c_cnt;
  logic        c_busy_after, c_done_after, c_timeout;

  task automatic run_capture(input int k, input logic [10:0] seed, input bit hold, input int budget);
    logic        prev_vv;
    logic [10:0] prev_vec;
    bit          finished;
    obs_vecs.delete();
    c_first_vv = 0; c_last_vv = 0; c_vv_cycles = 0; c_first_done = 0; c_done_cycles = 0;
    c_sig = '0; c_cnt = '0; c_busy_after = 1'b1; c_done_after = 1'b1;
    finished = 0; prev_vv = 1'b0; prev_vec = '0;
    sel = k;
    seed_v = seed;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_v[k] = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (o_vv) begin
        c_vv_cycles++;
        if (c_first_vv == 0) c_first_vv = c;
        c_last_vv = c;
        if (!prev_vv || o_vec != prev_vec) obs_vecs.push_back(o_vec);
      end
      prev_vv = o_vv;
      prev_vec = o_vec;
      if (c_first_done != 0 && c == c_first_done + 1) begin
        c_busy_after = o_busy;
        c_done_after = o_done;
        finished = 1;
        break;
      end else if (o_done) begin
        c_done_cycles++;
        if (c_first_done == 0) begin
          c_first_done = c;
          c_sig = o_sig;
          c_cnt = o_cnt;
        end
      end
      @(posedge clk); #1;
    end
    c_timeout = !finished;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      checks++;
      if (o_pk !== 38'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h expected 0", k, o_pk);
      end
    end
  endtask

  task automatic test_known_seed();
    model_run(11'h5A5, 10, 1, 4'h0);
    run_capture(0, 11'h5A5, 0, 40);
    checks++;
    if (c_timeout !== 1'b0) begin errors++; $display("FAIL known_seed_timeout: no done_o within budget"); end
    checks++;
    if (obs_vecs.size() < 2 || obs_vecs[0] !== {4'd11, 4'd4, 3'b101}) begin
      errors++; $display("FAIL known_seed_vec0: got %h expected %h", (obs_vecs.size() > 0) ? obs_vecs[0] : 11'h0, {4'd11, 4'd4, 3'b101});
    end
    checks++;
    if (obs_vecs.size() < 2 || obs_vecs[1] !== 11'h34A) begin
      errors++; $display("FAIL known_seed_vec1: got %h expected 34a", (obs_vecs.size() > 1) ? obs_vecs[1] : 11'h0);
    end
    checks++;
    if (c_sig !== exp_sig) begin errors++; $display("FAIL known_seed_sig: got %h expected %h", c_sig, exp_sig); end
  endtask

  task automatic test_hold_after_done();
    logic [15:0] s0;
    logic [7:0]  n0;
    s0 = c_sig; n0 = c_cnt;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (o_sig !== s0 || o_cnt !== n0) begin
      errors++; $display("FAIL hold_sig_cnt: got %h/%0d expected %h/%0d", o_sig, o_cnt, s0, n0);
    end
    checks++;
    if (o_vec !== exp_last) begin errors++; $display("FAIL hold_vector: got %h expected %h", o_vec, exp_last); end
    checks++;
    if ({o_vv, o_busy, o_done} !== 3'b000) begin
      errors++; $display("FAIL hold_flags: got vv/busy/done=%b expected 000", {o_vv, o_busy, o_done});
    end
  endtask

  task automatic test_zero_seed();
    model_run(11'h000, 10, 1, 4'h0);
    run_capture(0, 11'h000, 0, 40);
    checks++;
    if (obs_vecs.size() < 1 || obs_vecs[0] !== 11'h001) begin
      errors++; $display("FAIL zero_seed_vec0: got %h expected 001", (obs_vecs.size() > 0) ? obs_vecs[0] : 11'h7FF);
    end
    checks++;
    if (c_sig !== exp_sig || c_timeout) begin errors++; $display("FAIL zero_seed_sig: got %h expected %h", c_sig, exp_sig); end
  endtask

  task automatic test_timing_held_start();
    int span;
    span = N_OF[0] * (S_OF[0] + 1);
    run_capture(0, 11'($urandom_range(1, 2047)), 1, 40);
    checks++;
    if (c_first_vv != 1 || c_last_vv != span || c_vv_cycles != span) begin
      errors++; $display("FAIL timing_valid: got first=%0d last=%0d n=%0d expected 1/%0d/%0d", c_first_vv, c_last_vv, c_vv_cycles, span, span);
    end
    checks++;
    if (c_first_done != span + 1 || c_done_cycles != 1 || c_done_after !== 1'b0) begin
      errors++; $display("FAIL timing_done: got cycle=%0d n=%0d after=%b expected %0d/1/0", c_first_done, c_done_cycles, c_done_after, span + 1);
    end
    checks++;
    if (c_cnt !== 8'(N_OF[0]) || obs_vecs.size() != N_OF[0]) begin
      errors++; $display("FAIL timing_count: got cnt=%0d vecs=%0d expected %0d", c_cnt, obs_vecs.size(), N_OF[0]);
    end
    checks++;
    if (c_busy_after !== 1'b0) begin errors++; $display("FAIL timing_idle_after_done: got busy=%b expected 0", c_busy_after); end
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b1 || o_vv !== 1'b1) begin
      errors++; $display("FAIL timing_restart_from_idle: got busy=%b vv=%b expected 1/1", o_busy, o_vv);
    end
    start_v[0] = 1'b0;
    apply_reset();
  endtask

  task automatic test_misr_tied();
    tie_val = 4'h1;
    run_capture(1, 11'($urandom_range(1, 2047)), 0, 20);
    checks++;
    if (c_sig !== 16'h0003 || c_cnt !== 8'd2 || c_timeout) begin
      errors++; $display("FAIL misr_tied_one: got sig=%h cnt=%0d expected 0003/2", c_sig, c_cnt);
    end
    checks++;
    if (c_first_done != 5) begin errors++; $display("FAIL misr_tied_latency: got %0d expected 5", c_first_done); end
    tie_val = 4'h0;
    run_capture(1, 11'($urandom_range(1, 2047)), 0, 20);
    checks++;
    if (c_sig !== 16'h0000 || c_cnt !== 8'd2 || c_timeout) begin
      errors++; $display("FAIL misr_tied_zero: got sig=%h cnt=%0d expected 0000/2", c_sig, c_cnt);
    end
  endtask

  task automatic test_random_seeds();
    int ks [2] = '{0, 2};
    logic [10:0] seed;
    bit vec_ok;
    foreach (ks[j]) begin
      for (int r = 0; r < 3; r++) begin
        seed = 11'($urandom);
        model_run(seed, N_OF[ks[j]], 1, 4'h0);
        run_capture(ks[j], seed, 0, N_OF[ks[j]] * (S_OF[ks[j]] + 1) + 10);
        vec_ok = (obs_vecs.size() == exp_vecs.size());
        for (int i = 0; i < obs_vecs.size() && vec_ok; i++) if (obs_vecs[i] !== exp_vecs[i]) vec_ok = 0;
        checks++;
        if (!vec_ok) begin
          errors++; $display("FAIL rand_vectors dut%0d seed=%h: got %0d vectors, first %h, expected %0d first %h", ks[j], seed,
            obs_vecs.size(), (obs_vecs.size() > 0) ? obs_vecs[0] : 11'h0, exp_vecs.size(), exp_vecs[0]);
        end
        checks++;
        if (c_sig !== exp_sig || c_timeout) begin
          errors++; $display("FAIL rand_sig dut%0d seed=%h: got %h expected %h", ks[j], seed, c_sig, exp_sig);
        end
        checks++;
        if (c_first_done != N_OF[ks[j]] * (S_OF[ks[j]] + 1) + 1 || c_cnt !== 8'(N_OF[ks[j]])) begin
          errors++; $display("FAIL rand_latency dut%0d: got done@%0d cnt=%0d expected %0d/%0d", ks[j], c_first_done, c_cnt,
            N_OF[ks[j]] * (S_OF[ks[j]] + 1) + 1, N_OF[ks[j]]);
        end
      end
    end
  endtask

  task automatic test_ignore_start_while_busy();
    model_run(11'h3C1, 10, 1, 4'h0);
    sel = 0;
    seed_v = 11'h3C1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    seed_v = 11'h111;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (30) begin
      if (o_done) break;
      @(posedge clk); #1;
    end
    checks++;
    if (o_done !== 1'b1 || o_sig !== exp_sig) begin
      errors++; $display("FAIL ignore_start_busy: got done=%b sig=%h expected 1/%h", o_done, o_sig, exp_sig);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    sel = 0;
    seed_v = 11'h2B7;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_pk !== 38'h0) begin errors++; $display("FAIL reset_mid_run_outputs: got %h expected 0", o_pk); end
    saw_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL reset_mid_run_no_done: got done pulse expected none"); end
    model_run(11'h2B7, 10, 1, 4'h0);
    run_capture(0, 11'h2B7, 0, 40);
    checks++;
    if (c_sig !== exp_sig || c_timeout || obs_vecs.size() != 10 || obs_vecs[0] !== 11'h2B7) begin
      errors++; $display("FAIL reset_mid_run_restart: got sig=%h vecs=%0d expected %h/10", c_sig, obs_vecs.size(), exp_sig);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_v = '{1'b0, 1'b0, 1'b0};
    seed_v = '0;
    tie_val = 4'h0;
    sel = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_known_seed();
    test_hold_after_done();
    test_zero_seed();
    test_timing_held_start();
    test_misr_tied();
    test_random_seeds();
    test_ignore_start_while_busy();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_fuzz_engine.md
ALU_FUZZ_ENGINE -- requirements
Module: alu_fuzz_engine

Interface
REQ-001 Parameter NUM_VECTORS, default 10: vectors per run, legal range 1..255.
REQ-002 Parameter SETTLE, default 1: cycles each vector is held before result sampling, legal range 1..15.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start_i  input  1  begin a run; sampled only in IDLE.
REQ-006 seed_i  input  11  LFSR seed, captured on accepted start.
REQ-007 a_o  output  4  ALU operand A = lfsr[10:7].
REQ-008 b_o  output  4  ALU operand B = lfsr[6:3].
REQ-009 opcode_o  output  3  ALU opcode = lfsr[2:0].
REQ-010 vec_valid_o  output  1  high while a_o/b_o/opcode_o carry a live vector.
REQ-011 result_i  input  4  ALU result returned from the driven vector.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 done_o  output  1  one-cycle pulse at end of run.
REQ-014 signature_o  output  16  MISR compaction of all sampled results.
REQ-015 count_o  output  8  number of vectors sampled in current/last run.

Function
REQ-016 The block SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-017 IDLE with start_i=1 SHALL, on that edge: load lfsr=seed_i (11'h001 if seed_i==0), clear signature and count, clear settle counter, enter DRIVE.
REQ-018 DRIVE SHALL hold vector stable, vec_valid_o=1, increment settle counter; after SETTLE cycles in DRIVE, enter SAMPLE.
REQ-019 SAMPLE (one cycle, vector still driven, vec_valid_o=1) SHALL: sig <= {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} ^ {12'b0, result_i}; count++; lfsr <= {lfsr[9:0], lfsr[10]^lfsr[8]}; clear settle counter.
REQ-020 From SAMPLE: if updated count == NUM_VECTORS enter DONE, else enter DRIVE.
REQ-021 DONE SHALL assert done_o for exactly one cycle, vec_valid_o=0, then enter IDLE.
REQ-022 Per-vector period SHALL be SETTLE+1 cycles; start edge to done_o high SHALL be NUM_VECTORS*(SETTLE+1)+1 cycles.
REQ-023 start_i while busy_o=1 SHALL be ignored; start_i in DONE SHALL be ignored.
REQ-024 In IDLE, a_o/b_o/opcode_o SHALL hold the last lfsr value, vec_valid_o=0.
REQ-025 signature_o and count_o SHALL hold final values after DONE until next accepted start.
REQ-026 LFSR (x^11+x^9+1) SHALL never reach zero; count SHALL not wrap (NUM_VECTORS<=255).

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, lfsr=11'h000, signature_o=0, count_o=0, settle counter=0, a_o=b_o=opcode_o=0, vec_valid_o=0, busy_o=0, done_o=0.
REQ-028 Reset mid-run SHALL abort the run with no done_o pulse; first start after release SHALL behave as REQ-017.

Verification
REQ-029 Assert rst_n=0 mid-DRIVE -> all outputs 0 same cycle, no done_o; after release start runs cleanly.
REQ-030 seed_i=11'h5A5, start -> first vector A=11, B=4, opcode=3'b101; second vector lfsr=11'h34A (A=6, B=9, opcode=3'b010).
REQ-031 seed_i=0, start -> first vector lfsr=11'h001 (A=0, B=0, opcode=3'b001).
REQ-032 NUM_VECTORS=2, result_i tied 4'h1 -> signature_o=16'h0003, count_o=2; result_i tied 0 -> signature_o=16'h0000.
REQ-033 Defaults (N=10, SETTLE=1), start accepted at cycle 0 -> vec_valid_o high cycles 1-20, done_o high cycle 21 only, count_o=10; start_i held high throughout -> no restart until IDLE.
REQ-034 Bench connects a golden ALU model to a_o/b_o/opcode_o, recomputes MISR in the bench -> signature_o matches for 3 seeds and SETTLE in {1,3}.
